// File: rtl/fpu_uart_pkg.sv
// Shared UART definitions for the FPU test harness serial paths (RX and TX).
package fpu_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 868;
    localparam int unsigned TIMEOUT_BITS_DEF = 20;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: RX synchroniser, mid-bit sampling FSM and baud counter.
module uart_rx_byte
    import fpu_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       rx_idle_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    uart_state_e      state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             byte_valid_q;
    logic             frame_err_q;
    logic             rx_idle_q;

    // Synchronisers idle high so reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_idle_q    <= 1'b1;
        end else begin
            rx_meta_q    <= rx_i;
            rx_s_q       <= rx_meta_q;
            rx_prev_q    <= rx_s_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s_q) begin
                        state_q   <= START;
                        baud_q    <= '0;
                        rx_idle_q <= 1'b0;
                    end
                end
                START: begin
                    if (baud_q == HALF_M1) begin
                        baud_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            bit_q   <= '0;
                        end else begin
                            state_q   <= IDLE;
                            rx_idle_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_q == FULL_M1) begin
                        baud_q  <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_q == FULL_M1) begin
                        baud_q <= '0;
                        if (rx_s_q) begin
                            byte_valid_q <= 1'b1;
                            state_q      <= IDLE;
                            rx_idle_q    <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_q   <= IDLE;
                        rx_idle_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rx_idle_q <= 1'b1;
                end
            endcase
        end
    end

    assign rx_byte_o    = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;
    assign rx_idle_o    = rx_idle_q;

endmodule

// File: rtl/fpu_uart_operand_rx.sv
// Assembles two W-bit FPU operands from a UART byte stream and offers them via valid/ack.
module fpu_uart_operand_rx
    import fpu_uart_pkg::*;
#(
    parameter int unsigned W            = 32,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         RX,
    input  logic         operands_ack,
    output logic [W-1:0] Data_X,
    output logic [W-1:0] Data_Y,
    output logic         operands_valid,
    output logic         frame_err,
    output logic         overrun,
    output logic         sync_lost
);

    localparam int unsigned NBYTES   = W / 8;
    localparam int unsigned IDX_W    = $clog2(2 * NBYTES);
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             rx_frame_err;
    logic             rx_idle;

    logic [W-1:0]     data_x_q;
    logic [W-1:0]     data_y_q;
    logic             valid_q;
    logic             overrun_q;
    logic             sync_lost_q;
    logic [IDX_W-1:0] idx_q;
    logic [TO_W-1:0]  to_cnt_q;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (RX),
        .rx_byte_o    (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (rx_frame_err),
        .rx_idle_o    (rx_idle)
    );

    // An ack in the same cycle as a new byte frees the pair first, so the byte is kept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_x_q    <= '0;
            data_y_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            sync_lost_q <= 1'b0;
            idx_q       <= '0;
            to_cnt_q    <= '0;
        end else begin
            overrun_q   <= 1'b0;
            sync_lost_q <= 1'b0;

            if (valid_q && operands_ack) begin
                valid_q <= 1'b0;
            end

            if (byte_valid) begin
                to_cnt_q <= '0;
                if (valid_q && !operands_ack) begin
                    overrun_q <= 1'b1;
                end else begin
                    for (int unsigned b = 0; b < NBYTES; b++) begin
                        if (idx_q == IDX_W'(b)) begin
                            data_x_q[8*b +: 8] <= rx_byte;
                        end
                        if (idx_q == IDX_W'(b + NBYTES)) begin
                            data_y_q[8*b +: 8] <= rx_byte;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
            end else if (rx_frame_err) begin
                idx_q    <= '0;
                to_cnt_q <= '0;
            end else if (idx_q != '0 && rx_idle) begin
                // Partial frame with a silent line: give up after the timeout window.
                if (to_cnt_q == TO_LAST) begin
                    idx_q       <= '0;
                    to_cnt_q    <= '0;
                    sync_lost_q <= 1'b1;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign Data_X         = data_x_q;
    assign Data_Y         = data_y_q;
    assign operands_valid = valid_q;
    assign frame_err      = rx_frame_err;
    assign overrun        = overrun_q;
    assign sync_lost      = sync_lost_q;

endmodule

// File: doc/fpu_uart_operand_rx.md
Name: fpu_uart_operand_rx

Overview:
- Serial front end for the FPU test harness. Receives 8N1 UART bytes on RX and assembles two W-bit IEEE operands, Data_X then Data_Y.
- Presents the pair to the FPU control FSM through a valid/ack handshake. It replaces the fixed operand ROMs so a host PC can stream test vectors.
- Sits directly upstream of the add/subtract or multiply function unit, mirroring the existing UART transmit path downstream.

Parameters:
- W, 32, operand width in bits (32 or 64; must be a multiple of 8).
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200).
- TIMEOUT_BITS, 20, idle bit-periods mid-frame before the partial operand frame is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- RX  in  1  asynchronous UART serial input; idle high.
- operands_ack  in  1  consumer has taken Data_X/Data_Y.
- Data_X  out  W  operand X.
- Data_Y  out  W  operand Y.
- operands_valid  out  1  Data_X/Data_Y hold a complete pair.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte dropped because a pair is still pending.
- sync_lost  out  1  one-cycle pulse: inter-byte timeout discarded a partial frame.

Behaviour:
- Reset, sampled on the clk edge when rst=0:
  - Data_X = Data_Y = 0.
  - operands_valid, frame_err, overrun and sync_lost = 0.
  - Byte index = 0, receiver in IDLE, timeout counter = 0.
  - Reset mid-byte or mid-frame discards everything received so far.
- RX synchronisation: 2-flop synchroniser. All logic uses the synchronised signal rx_s, which adds 2 cycles of latency.
- Byte receiver FSM, states IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: a 1->0 transition on rx_s moves to START and clears the baud counter.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s. If 0, go to DATA. If 1 (glitch), return to IDLE with no flag.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into the byte register. Then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx_s=1: byte_valid pulses for 1 cycle on the cycle after the sample; return to IDLE.
    - rx_s=0: frame_err pulses, the byte is discarded, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s=1, then go to IDLE. A break condition never yields bytes.
- Operand assembler:
  - NBYTES = W/8. The byte index runs 0..2*NBYTES-1.
  - Bytes 0..NBYTES-1 fill Data_X, least-significant byte first.
  - Bytes NBYTES..2*NBYTES-1 fill Data_Y, least-significant byte first.
  - Data_X/Data_Y update in place as bytes arrive, but are only meaningful while operands_valid=1.
  - On the byte_valid that writes the last byte: operands_valid=1 on the next cycle and the index wraps to 0.
- Handshake:
  - operands_valid stays high until a cycle with operands_ack=1, then drops on the following edge.
  - Data_X/Data_Y are stable for the whole time operands_valid=1.
  - operands_ack while operands_valid=0 is ignored.
- Overrun:
  - A byte_valid while operands_valid=1 is dropped: overrun pulses and registers/index are unchanged.
  - If the ack and the byte_valid arrive in the same cycle, the ack wins. valid drops and the byte is accepted as byte 0 of the next frame, with no overrun.
- Timeout:
  - While the index is not 0 and the receiver is in IDLE, count clk cycles. Any start bit clears the count.
  - At TIMEOUT_BITS*CLKS_PER_BIT cycles: index resets to 0 and sync_lost pulses. Data_X/Data_Y are not cleared.
  - A frame_err also resets the index to 0 (frame_err only, no sync_lost).
- Width rules:
  - Baud counter width = $clog2(CLKS_PER_BIT).
  - Timeout counter width = $clog2(TIMEOUT_BITS*CLKS_PER_BIT+1).
  - Index width = $clog2(2*NBYTES).

Decomposition:
- Shared package fpu_uart_pkg: receiver state enum (IDLE, START, DATA, STOP, WAIT_IDLE) and localparam defaults CLKS_PER_BIT_DEF=868, TIMEOUT_BITS_DEF=20. The TX side reuses the same enum and constants.
- One sub-module, uart_rx_byte:
  - Contains the synchroniser, the receiver FSM and the baud counter.
  - Outputs rx_byte[7:0], byte_valid, frame_err and rx_idle.
  - The assembler, handshake and timeout logic stay in the top.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_BITS=4, W=32):
- Send 00 00 80 3F 00 00 00 40, ack 5 cycles after valid -> Data_X=0x3F800000, Data_Y=0x40000000. operands_valid rises 1 cycle after the last byte_valid and falls the cycle after the ack.
- Hold pending pair, send 1 extra byte 0x55 -> overrun pulses once, Data_X/Data_Y unchanged. After ack, a new 8-byte frame is assembled correctly.
- Send byte 0xA5 with stop bit driven low -> frame_err pulses, no byte accepted, index=0. The next valid frame is assembled correctly.
- Send 3 bytes, idle 64+ cycles -> sync_lost pulses once. A fresh 8-byte frame of 0xC0490FDB / 0x3F000000 then assembles correctly.
- 4-cycle low glitch on RX in IDLE -> no byte_valid and no flags. Drive rst=0 mid-byte of frame byte 5 -> all outputs 0 and index 0; the next full frame assembles.
- Ack asserted in the same cycle as byte 0 of the next frame arrives -> valid drops, the byte is accepted as byte 0, overrun stays 0.
